fir_mac_scheduler: RTL and testbench

- Sequences the FIR datapath for one output sample: writes the new input into the sample ring buffer, then walks all taps in groups of NUM_PIPELINES parallel MAC lanes, then waits out the MAC pipeline and hands the result to the serializer.
- Sits between the deserializer (sample-valid handshake) and the serializer (result-ready handshake).
- Drives buffer/ROM addresses and MAC control strobes only; it carries no sample data.

---
 rtl/fir_mac_scheduler_if.sv | 35 +++
 rtl/fir_mac_scheduler.sv | 121 ++++++++++++
 tb/tb_fir_mac_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_scheduler_if.sv
// Handshake and address/strobe bundle between the FIR MAC scheduler and its
// neighbours (deserializer, sample buffer, coefficient ROM, MAC lanes, serializer).
interface fir_mac_scheduler_if #(
    parameter int FIR_DEPTH     = 256,
    parameter int NUM_PIPELINES = 8
);
    localparam int AW = $clog2(FIR_DEPTH);
    localparam int G  = FIR_DEPTH / NUM_PIPELINES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    logic          i_en;
    logic          i_sample_valid;
    logic          o_ready;
    logic          o_smp_we;
    logic [AW-1:0] o_smp_waddr;
    logic [AW-1:0] o_smp_base;
    logic [GW-1:0] o_coef_grp;
    logic          o_mac_en;
    logic          o_mac_clr;
    logic          o_result_valid;
    logic          i_out_ready;
    logic [15:0]   o_overrun_cnt;

    modport master (
        input  i_en, i_sample_valid, i_out_ready,
        output o_ready, o_smp_we, o_smp_waddr, o_smp_base, o_coef_grp,
               o_mac_en, o_mac_clr, o_result_valid, o_overrun_cnt
    );

    modport slave (
        output i_en, i_sample_valid, i_out_ready,
        input  o_ready, o_smp_we, o_smp_waddr, o_smp_base, o_coef_grp,
               o_mac_en, o_mac_clr, o_result_valid, o_overrun_cnt
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Sequences one FIR output: sample write, grouped MAC issue, pipeline drain, result handoff.
// Define FIR_SCHED_OVERRUN_CNT_EN to enable the saturating dropped-sample counter.
module fir_mac_scheduler #(
    parameter int FIR_DEPTH     = 256,
    parameter int NUM_PIPELINES = 8,
    parameter int MAC_LATENCY   = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fir_mac_scheduler_if.master   bus
);
    localparam int AW      = $clog2(FIR_DEPTH);
    localparam int G       = FIR_DEPTH / NUM_PIPELINES;
    localparam int GW      = (G > 1) ? $clog2(G) : 1;
    localparam int NP_LOG2 = $clog2(NUM_PIPELINES);
    localparam int DW      = $clog2(MAC_LATENCY + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RUN,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grp_q;
    logic [DW-1:0] drain_q;
    logic [AW-1:0] wr_ptr_q;
    logic          last_grp;
    logic          drain_done;

    assign last_grp   = (grp_q == GW'(G - 1));
    assign drain_done = (drain_q == DW'(MAC_LATENCY - 1));

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            grp_q    <= '0;
            drain_q  <= '0;
            wr_ptr_q <= '0;
        end else if (bus.i_en) begin
            state_q <= state_d;
            case (state_q)
                ST_WRITE: grp_q <= '0;
                ST_RUN: begin
                    if (last_grp) begin
                        grp_q    <= '0;
                        drain_q  <= '0;
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                ST_DRAIN: drain_q <= drain_q + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: every output and state_d gets a default first so no path leaves them unassigned (no latches).
    always_comb begin
        state_d            = state_q;
        bus.o_ready        = 1'b0;
        bus.o_smp_we       = 1'b0;
        bus.o_smp_waddr    = '0;
        bus.o_smp_base     = '0;
        bus.o_coef_grp     = '0;
        bus.o_mac_en       = 1'b0;
        bus.o_mac_clr      = 1'b0;
        bus.o_result_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.o_ready = bus.i_en;
                if (bus.i_sample_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                bus.o_smp_we    = bus.i_en;
                bus.o_smp_waddr = wr_ptr_q;
                state_d         = ST_RUN;
            end
            ST_RUN: begin
                // Lane 0 of group g reads the sample g*NUM_PIPELINES older than the newest one.
                bus.o_mac_en   = bus.i_en;
                bus.o_mac_clr  = bus.i_en && (grp_q == '0);
                bus.o_coef_grp = grp_q;
                bus.o_smp_base = wr_ptr_q - (AW'(grp_q) << NP_LOG2);
                if (last_grp) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_OUT;
            end
            ST_OUT: begin
                // Not gated by i_en: a frozen block keeps presenting its finished result.
                bus.o_result_valid = 1'b1;
                if (bus.i_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FIR_SCHED_OVERRUN_CNT_EN
    logic [15:0] overrun_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overrun_q <= '0;
        end else if (bus.i_en && bus.i_sample_valid && (state_q != ST_IDLE)
                     && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign bus.o_overrun_cnt = overrun_q;
`else
    assign bus.o_overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: per-cycle vector table plus multi-cycle corner sequences.
module tb_fir_mac_scheduler;
    localparam int FIR_DEPTH     = 256;
    localparam int NUM_PIPELINES = 8;
    localparam int MAC_LATENCY   = 3;
    localparam int G             = FIR_DEPTH / NUM_PIPELINES;
    localparam int RES_CYC       = G + 2 + MAC_LATENCY;

    logic tb_clk = 1'b0;
    logic rst_n;
    always #5 tb_clk = ~tb_clk;

    fir_mac_scheduler_if #(.FIR_DEPTH(FIR_DEPTH), .NUM_PIPELINES(NUM_PIPELINES)) bus ();

    fir_mac_scheduler #(
        .FIR_DEPTH    (FIR_DEPTH),
        .NUM_PIPELINES(NUM_PIPELINES),
        .MAC_LATENCY  (MAC_LATENCY)
    ) dut (
        .i_clk  (tb_clk),
        .i_rst_n(rst_n),
        .bus    (bus.master)
    );

    typedef struct {
        int         cyc;
        logic       we;
        logic       mac_en;
        logic       clr;
        logic       rv;
        logic       ready;
        logic [7:0] waddr;
        logic [7:0] base;
        logic [4:0] grp;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        check($sformatf("c%0d_we", v.cyc), 32'(bus.o_smp_we), 32'(v.we));
        check($sformatf("c%0d_mac_en", v.cyc), 32'(bus.o_mac_en), 32'(v.mac_en));
        check($sformatf("c%0d_clr", v.cyc), 32'(bus.o_mac_clr), 32'(v.clr));
        check($sformatf("c%0d_rv", v.cyc), 32'(bus.o_result_valid), 32'(v.rv));
        check($sformatf("c%0d_ready", v.cyc), 32'(bus.o_ready), 32'(v.ready));
        check($sformatf("c%0d_waddr", v.cyc), 32'(bus.o_smp_waddr), 32'(v.waddr));
        check($sformatf("c%0d_base", v.cyc), 32'(bus.o_smp_base), 32'(v.base));
        check($sformatf("c%0d_grp", v.cyc), 32'(bus.o_coef_grp), 32'(v.grp));
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.i_en           = 1'b1;
        bus.i_sample_valid = 1'b0;
        bus.i_out_ready    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One sample with i_out_ready high; returns the cycle at which the result appeared.
    task automatic run_quiet(output int lat);
        bus.i_out_ready    = 1'b1;
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
        lat = 1;
        while (!bus.o_result_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (lat >= 200) check("rv_timeout", 32'(bus.o_result_valid), 32'd1);
        tick();
    endtask

    task automatic run_detail(input string tag, input logic [7:0] wp,
                              input logic [7:0] exp_b0, input logic [7:0] exp_b1);
        int         err;
        int         lat;
        logic [7:0] b0, b1, mb;
        err = 0;
        b0  = '0;
        b1  = '0;
        bus.i_out_ready    = 1'b1;
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
        check({tag, "_we"}, 32'(bus.o_smp_we), 32'd1);
        check({tag, "_waddr"}, 32'(bus.o_smp_waddr), 32'(wp));
        lat = 1;
        for (int g = 0; g < G; g++) begin
            tick();
            lat++;
            mb = wp - 8'(g * NUM_PIPELINES);
            if (g == 0) b0 = bus.o_smp_base;
            if (g == 1) b1 = bus.o_smp_base;
            if (bus.o_mac_en !== 1'b1 || bus.o_coef_grp !== 5'(g) || bus.o_smp_base !== mb
                || bus.o_mac_clr !== (g == 0)) err++;
        end
        check({tag, "_run_errs"}, 32'(err), 32'd0);
        check({tag, "_base_g0"}, 32'(b0), 32'(exp_b0));
        check({tag, "_base_g1"}, 32'(b1), 32'(exp_b1));
        while (!bus.o_result_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(RES_CYC));
        tick();
    endtask

    initial begin
        int macs, clrs, vi, err, lat, issues, hold_err;
        logic paused, rv_seen;

        vecs[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   5'd0};
        vecs[1] = '{2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0,   5'd0};
        vecs[2] = '{3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd248, 5'd1};
        vecs[3] = '{12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd176, 5'd10};
        vecs[4] = '{33, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd8,   5'd31};
        vecs[5] = '{34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   5'd0};
        vecs[6] = '{36, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0,   5'd0};
        vecs[7] = '{37, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0,   5'd0};

        // Reset state, sampled while reset is still asserted.
        rst_n              = 1'b0;
        bus.i_en           = 1'b1;
        bus.i_sample_valid = 1'b0;
        bus.i_out_ready    = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_we", 32'(bus.o_smp_we), 32'd0);
        check("rst_mac_en", 32'(bus.o_mac_en), 32'd0);
        check("rst_rv", 32'(bus.o_result_valid), 32'd0);
        check("rst_base", 32'(bus.o_smp_base), 32'd0);
        check("rst_ovr", 32'(bus.o_overrun_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single sample against the cycle table, then backpressure in OUT.
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
        macs = 0;
        clrs = 0;
        vi   = 0;
        for (int c = 1; c <= RES_CYC; c++) begin
            if (vi < 8 && vecs[vi].cyc == c) begin
                apply_vec(vecs[vi]);
                vi++;
            end
            if (bus.o_mac_en) macs++;
            if (bus.o_mac_clr) clrs++;
            if (c < RES_CYC) tick();
        end
        check("mac_issue_count", 32'(macs), 32'd32);
        check("mac_clr_count", 32'(clrs), 32'd1);
        err = 0;
        repeat (20) begin
            tick();
            if (bus.o_result_valid !== 1'b1 || bus.o_ready !== 1'b0) err++;
        end
        check("bp_hold_errs", 32'(err), 32'd0);
        bus.i_out_ready = 1'b1;
        tick();
        check("bp_release_rv", 32'(bus.o_result_valid), 32'd0);
        check("bp_release_ready", 32'(bus.o_ready), 32'd1);

        // Addressing across three consecutive samples.
        do_reset();
        run_quiet(lat);
        check("addr_s0_latency", 32'(lat), 32'(RES_CYC));
        run_quiet(lat);
        run_detail("addr_s2", 8'd2, 8'd2, 8'd250);

        // Write pointer wrap on the 257th sample.
        do_reset();
        for (int s = 0; s < FIR_DEPTH; s++) run_quiet(lat);
        run_detail("wrap_s256", 8'd0, 8'd0, 8'd248);

        // Enable low for five cycles while group 10 is presented.
        bus.i_out_ready    = 1'b1;
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
        issues   = 0;
        hold_err = 0;
        paused   = 1'b0;
        for (int c = 1; c < 100 && !bus.o_result_valid; c++) begin
            if (!paused && bus.o_mac_en && bus.o_coef_grp == 5'd10) begin
                bus.i_en = 1'b0;
                #1;
                repeat (5) begin
                    if (bus.o_mac_en !== 1'b0 || bus.o_coef_grp !== 5'd10) hold_err++;
                    tick();
                end
                bus.i_en = 1'b1;
                #1;
                paused = 1'b1;
            end
            if (bus.o_mac_en) issues++;
            tick();
        end
        check("en_paused", 32'(paused), 32'd1);
        check("en_hold_errs", 32'(hold_err), 32'd0);
        check("en_issue_total", 32'(issues), 32'd32);
        check("en_rv", 32'(bus.o_result_valid), 32'd1);
        tick();

        // Reset in the middle of the group walk.
        bus.i_sample_valid = 1'b1;
        tick();
        bus.i_sample_valid = 1'b0;
        for (int c = 1; c < 60 && !(bus.o_mac_en && bus.o_coef_grp == 5'd15); c++) tick();
        check("rst_mid_reached_g15", 32'(bus.o_coef_grp), 32'd15);
        rst_n = 1'b0;
        tick();
        check("rst_mid_ready", 32'(bus.o_ready), 32'd1);
        check("rst_mid_mac_en", 32'(bus.o_mac_en), 32'd0);
        rst_n   = 1'b1;
        rv_seen = 1'b0;
        repeat (45) begin
            tick();
            if (bus.o_result_valid) rv_seen = 1'b1;
        end
        check("rst_mid_no_result", 32'(rv_seen), 32'd0);
        check("rst_mid_idle_ready", 32'(bus.o_ready), 32'd1);

        // Sample-valid held high through a whole computation.
        do_reset();
        bus.i_out_ready    = 1'b1;
        bus.i_sample_valid = 1'b1;
        tick();
        repeat (RES_CYC) tick();
`ifdef FIR_SCHED_OVERRUN_CNT_EN
        check("overrun_cnt", 32'(bus.o_overrun_cnt), 32'd37);
`else
        check("overrun_cnt", 32'(bus.o_overrun_cnt), 32'd0);
`endif
        repeat (62) tick();
        bus.i_sample_valid = 1'b0;
        for (int c = 0; c < 100 && !bus.o_ready; c++) tick();
        check("overrun_back_idle", 32'(bus.o_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
